pci_rr_arbiter: RTL and testbench
=================================

// Module: pci_rr_arbiter
// PURPOSE
//   Central PCI bus arbiter sitting directly upstream of every Device: samples the active-low
//   req lines and the shared frame/irdy, and drives the active-low gnt lines the Devices use
//   to enter bus_granted. Round-robin fairness among masters, at most one grant low at a time.
//   Revokes an unused grant after a latency timeout.
// PARAMETERS
//   N_DEV        4    number of masters (req/gnt width), 2..8
//   MAX_LAT      16   cycles a grant may stay unused (no frame) before it is revoked
//   PARK_DEV     0    master parked on when idle (used only with PCI_ARB_PARK_EN)
// PORTS
//   clk        in   1                 bus clock; all state updates on posedge
//   reset      in   1                 asynchronous, active-high; forces all outputs to reset values
//   req        in   N_DEV             active-low bus requests, one per master
//   frame      in   1                 shared PCI frame, active low (bus pulled high when idle)
//   irdy       in   1                 shared PCI irdy, active low
//   gnt        out  N_DEV             active-low grants, registered, one-cold or all ones
//   gnt_id     out  $clog2(N_DEV)     index of current/last granted master
//   gnt_valid  out  1                 1 while any gnt bit is low
//   bus_busy   out  1                 1 while a granted transaction is in progress
//   timeout    out  1                 one-cycle pulse when an unused grant is revoked
// BEHAVIOUR
//   Reset (async): gnt=all 1s, gnt_id=0, gnt_valid=0, bus_busy=0, timeout=0, state=IDLE,
//     last_owner=N_DEV-1 (master 0 wins first), wait_cnt=0. Reset mid-grant or mid-transaction
//     releases gnt immediately, no completion of the transfer.
//   All outputs registered; gnt_valid == ~&gnt at all times.
//   Winner = first index with req low scanning last_owner+1, +2, ... mod N_DEV (wraps).
//   IDLE: if any req low at posedge -> GRANT; gnt[winner]=0, gnt_id=winner, wait_cnt=0.
//     Latency: req low sampled at edge k -> gnt low from edge k onward (1 register stage).
//     No req -> stay IDLE, gnt all 1s.
//   GRANT: priority order at each posedge:
//     1. frame==0 -> BUSY; gnt all 1s, bus_busy=1, last_owner=gnt_id.
//     2. req[gnt_id]==1 (withdrawn) -> IDLE; gnt all 1s, last_owner unchanged.
//     3. wait_cnt==MAX_LAT-1 -> IDLE; gnt all 1s, timeout=1 for one cycle,
//        last_owner=gnt_id (offender loses its turn).
//     4. else wait_cnt+1. Other reqs changing while in GRANT are ignored.
//   BUSY: gnt held all 1s (no pre-grant). When frame==1 && irdy==1 sampled -> IDLE,
//     bus_busy=0. Guaranteed >=1 idle turnaround cycle before next grant.
//   frame low while IDLE (foreign/unexpected master) -> BUSY with last_owner unchanged.
//   wait_cnt width $clog2(MAX_LAT+1); never wraps (saturates at MAX_LAT-1 by rule 3).
//   gnt_id holds last value when gnt all 1s.
// CONFIGURATION
//   PCI_ARB_PARK_EN defined: bus parking. In IDLE with no req low, gnt[PARK_DEV]=0,
//     gnt_id=PARK_DEV (state PARK). Parked master asserting frame -> BUSY, last_owner=PARK_DEV.
//     Any req low from another master -> gnt all 1s for one cycle, then normal GRANT to winner.
//     req from PARK_DEV itself -> GRANT directly without dead cycle, wait_cnt=0.
//     Parking begins on first posedge after reset (reset value still all 1s).
//   PCI_ARB_PARK_EN undefined: no PARK state; gnt all 1s whenever no req is pending.
// TESTING
//   T1 reset released, req=4'b1110 -> gnt=4'b1110, gnt_id=0 after next edge; frame=0 two
//      cycles later -> gnt=4'b1111, bus_busy=1; frame=irdy=1 -> bus_busy=0 next edge.
//   T2 req=4'b1010 held, each master does one 2-cycle transfer -> grant order 0,2,0,2;
//      then req=4'b0000 -> order continues 3,0,1,2 (wrap from last_owner).
//   T3 req=4'b1101, frame never asserted -> gnt=4'b1101 for exactly 16 cycles, timeout
//      pulse 1 cycle, gnt=4'b1111; with req=4'b1100 next grant goes to 0, not 1.
//   T4 req0 low granted, req0 released before frame -> gnt=4'b1111 next edge, timeout=0;
//      re-request -> master 0 granted again (last_owner unchanged).
//   T5 reset asserted mid-BUSY and mid-GRANT (between clock edges) -> gnt=4'b1111,
//      bus_busy=0, gnt_valid=0 immediately; after release req=4'b0111 -> gnt=4'b0111.
//   T6 PCI_ARB_PARK_EN, PARK_DEV=0, req=4'b1111 -> gnt=4'b1110 (parked); req=4'b1011 ->
//      one cycle gnt=4'b1111 then gnt=4'b1011; repeat T1-T5 with and without the macro.

Source files
------------

// File: rtl/pci_rr_arbiter.sv
// Central PCI bus arbiter: round-robin grant over active-low req lines, at most one gnt low,
// unused grants revoked after MAX_LAT cycles. All outputs are registered.
// Optional bus parking is enabled by defining PCI_ARB_PARK_EN.
module pci_rr_arbiter #(
  parameter int unsigned N_DEV    = 4,
  parameter int unsigned MAX_LAT  = 16,
  parameter int unsigned PARK_DEV = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_DEV-1:0]         req,
  input  logic                     frame,
  input  logic                     irdy,
  output logic [N_DEV-1:0]         gnt,
  output logic [$clog2(N_DEV)-1:0] gnt_id,
  output logic                     gnt_valid,
  output logic                     bus_busy,
  output logic                     timeout
);

  localparam int unsigned IdxW = $clog2(N_DEV);
  localparam int unsigned CntW = $clog2(MAX_LAT + 1);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_DEV - 1);
  localparam logic [CntW-1:0] LatMax  = CntW'(MAX_LAT - 1);
`ifdef PCI_ARB_PARK_EN
  localparam logic [IdxW-1:0] ParkIdx = IdxW'(PARK_DEV);
`endif

  // Elaboration-time sanity checks on the configuration
  if (N_DEV < 2 || N_DEV > 8) begin : g_chk_n_dev
    $error("pci_rr_arbiter: N_DEV must be in 2..8");
  end
  if (MAX_LAT < 1) begin : g_chk_max_lat
    $error("pci_rr_arbiter: MAX_LAT must be at least 1");
  end
  if (PARK_DEV >= N_DEV) begin : g_chk_park_dev
    $error("pci_rr_arbiter: PARK_DEV must be below N_DEV");
  end

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StBusy,
    StPark
  } state_e;

  state_e            state_q;
  logic [IdxW-1:0]   last_owner_q;
  logic [CntW-1:0]   wait_cnt_q;

  logic [IdxW-1:0]   winner;
  logic [IdxW-1:0]   cand;
  logic              any_req;

  // Active-low grant vector with only bit idx asserted
  function automatic logic [N_DEV-1:0] onecold(input logic [IdxW-1:0] idx);
    logic [N_DEV-1:0] v;
    v      = '1;
    v[idx] = 1'b0;
    return v;
  endfunction

  // Round-robin pick: first requesting master after last_owner, wrapping around
  always_comb begin
    winner  = last_owner_q;
    any_req = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= N_DEV; i++) begin
      cand = IdxW'((32'(last_owner_q) + i) % N_DEV);
      if (!any_req && !req[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  // Arbitration FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_owner_q <= LastIdx;
      wait_cnt_q   <= '0;
      gnt          <= '1;
      gnt_id       <= '0;
      gnt_valid    <= 1'b0;
      bus_busy     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!frame) begin
            // Someone else is driving the bus; track it without touching fairness
            state_q  <= StBusy;
            bus_busy <= 1'b1;
          end else if (any_req) begin
            state_q    <= StGrant;
            gnt        <= onecold(winner);
            gnt_id     <= winner;
            gnt_valid  <= 1'b1;
            wait_cnt_q <= '0;
          end
`ifdef PCI_ARB_PARK_EN
          else begin
            state_q   <= StPark;
            gnt       <= onecold(ParkIdx);
            gnt_id    <= ParkIdx;
            gnt_valid <= 1'b1;
          end
`endif
        end

        StGrant: begin
          if (!frame) begin
            state_q      <= StBusy;
            gnt          <= '1;
            gnt_valid    <= 1'b0;
            bus_busy     <= 1'b1;
            last_owner_q <= gnt_id;
          end else if (req[gnt_id]) begin
            // Withdrawn before use: the master keeps its turn
            state_q   <= StIdle;
            gnt       <= '1;
            gnt_valid <= 1'b0;
          end else if (wait_cnt_q == LatMax) begin
            // Latency expired: the offender goes to the back of the rotation
            state_q      <= StIdle;
            gnt          <= '1;
            gnt_valid    <= 1'b0;
            timeout      <= 1'b1;
            last_owner_q <= gnt_id;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
        end

        StBusy: begin
          // Return via IDLE so a turnaround cycle always precedes the next grant
          if (frame && irdy) begin
            state_q  <= StIdle;
            bus_busy <= 1'b0;
          end
        end

`ifdef PCI_ARB_PARK_EN
        StPark: begin
          if (!frame) begin
            state_q      <= StBusy;
            gnt          <= '1;
            gnt_valid    <= 1'b0;
            bus_busy     <= 1'b1;
            last_owner_q <= ParkIdx;
          end else if (!req[ParkIdx]) begin
            // Parked master already holds gnt: promote to a normal grant, no dead cycle
            state_q    <= StGrant;
            wait_cnt_q <= '0;
          end else if (any_req) begin
            // Drop the park grant for one cycle before granting a different master
            state_q   <= StIdle;
            gnt       <= '1;
            gnt_valid <= 1'b0;
          end
        end
`endif

        default: begin
          state_q   <= StIdle;
          gnt       <= '1;
          gnt_valid <= 1'b0;
          bus_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Self-checking bench for pci_rr_arbiter: behavioural owner/age model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pci_rr_arbiter;

  localparam int N    = 4;
  localparam int LAT  = 16;
  localparam int PARK = 0;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req   = '1;
  logic         frame = 1'b1;
  logic         irdy  = 1'b1;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         gnt_valid;
  logic         bus_busy;
  logic         timeout;

  pci_rr_arbiter #(
    .N_DEV   (N),
    .MAX_LAT (LAT),
    .PARK_DEV(PARK)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .frame    (frame),
    .irdy     (irdy),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid),
    .bus_busy (bus_busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the grant, when it was granted, and bus occupancy
  int           m_owner;   // -1 when no gnt is low
  int           m_gid;
  int           m_last;
  int           m_gstart;
  int           m_w;
  int           cyc;
  bit           m_busy;
  bit           m_to;
  bit           m_parked;
  bit           chk_en = 1'b0;
  logic [N-1:0] m_gnt_exp;

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (!r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner  = -1;
      m_gid    = 0;
      m_last   = N - 1;
      m_busy   = 1'b0;
      m_to     = 1'b0;
      m_parked = 1'b0;
      m_gstart = 0;
    end else begin
      cyc++;
      m_to = 1'b0;
      if (m_busy) begin
        if (frame && irdy) m_busy = 1'b0;
      end else if (m_owner >= 0 && m_parked) begin
        if (!frame) begin
          m_busy = 1'b1; m_last = PARK; m_owner = -1; m_parked = 1'b0;
        end else if (!req[PARK]) begin
          m_parked = 1'b0; m_gstart = cyc;
        end else if (req != '1) begin
          m_owner = -1; m_parked = 1'b0;
        end
      end else if (m_owner >= 0) begin
        if (!frame) begin
          m_busy = 1'b1; m_last = m_owner; m_owner = -1;
        end else if (req[m_owner]) begin
          m_owner = -1;
        end else if (cyc - m_gstart == LAT) begin
          m_to = 1'b1; m_last = m_owner; m_owner = -1;
        end
      end else begin
        m_w = rr_pick(req, m_last);
        if (!frame) m_busy = 1'b1;
        else if (m_w >= 0) begin
          m_owner = m_w; m_gid = m_w; m_gstart = cyc;
        end
`ifdef PCI_ARB_PARK_EN
        else begin
          m_owner = PARK; m_gid = PARK; m_parked = 1'b1;
        end
`endif
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      m_gnt_exp = '1;
      if (m_owner >= 0) m_gnt_exp[m_owner] = 1'b0;
      check("gnt", gnt, m_gnt_exp);
      check("gnt_id", gnt_id, m_gid);
      check("gnt_valid", gnt_valid, m_owner >= 0);
      check("bus_busy", bus_busy, m_busy);
      check("timeout", timeout, m_to);
      check("valid_vs_gnt", gnt_valid, ~&gnt);
    end
  end

  task automatic reset_pulse();
    @(negedge clk);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  // Wait for a grant, then run a short transfer as the granted master
  task automatic xfer(output int who);
    int n;
    n = 0;
    while (!gnt_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("xfer_wait_grant", gnt_valid, 1'b1);
    if (!gnt_valid) begin
      who = -1;
    end else begin
      who = gnt_id;
      frame = 1'b0; irdy = 1'b0;
      @(negedge clk);
      frame = 1'b1; irdy = 1'b0;
      @(negedge clk);
      frame = 1'b1; irdy = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int who;
  int cnt;
  int pf;
  int exp_a[4] = '{0, 2, 0, 2};
  int exp_b[4] = '{3, 0, 1, 2};

  initial begin
    #1 reset = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    // T1: grant, transaction, release
    req = 4'b1110; reset = 1'b0;
    @(negedge clk);
    check("t1_gnt", gnt, 4'b1110);
    check("t1_gnt_id", gnt_id, 0);
    @(negedge clk);
    frame = 1'b0; irdy = 1'b0; req = 4'b1111;
    @(negedge clk);
    check("t1_busy_gnt", gnt, 4'b1111);
    check("t1_busy", bus_busy, 1'b1);
    frame = 1'b1; irdy = 1'b1;
    @(negedge clk);
    check("t1_idle", bus_busy, 1'b0);

    // T2: rotation between two masters, then among all four
    req = 4'b1010;
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      xfer(who);
      check("t2_order_a", who, exp_a[i]);
    end
    req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      xfer(who);
      check("t2_order_b", who, exp_b[i]);
    end
    req = 4'b1111;

    // T3: unused grant revoked after MAX_LAT cycles
    req = 4'b1101;
    reset_pulse();
    cnt = 0;
    @(negedge clk);
    while (gnt == 4'b1101 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("t3_grant_cycles", cnt, LAT);
    check("t3_timeout", timeout, 1'b1);
    check("t3_revoked", gnt, 4'b1111);
    req = 4'b1100;
    @(negedge clk);
    check("t3_next_gnt", gnt, 4'b1110);
    check("t3_timeout_pulse", timeout, 1'b0);
    req = 4'b1111;

    // T4: withdrawn request keeps its turn
    req = 4'b1110;
    reset_pulse();
    @(negedge clk);
    check("t4_gnt", gnt, 4'b1110);
    req = 4'b1111;
    @(negedge clk);
    check("t4_released", gnt, 4'b1111);
    check("t4_no_timeout", timeout, 1'b0);
    req = 4'b1100;
    @(negedge clk);
    check("t4_regrant", gnt, 4'b1110);
    req = 4'b1111;

    // T5: asynchronous reset mid-BUSY and mid-GRANT
    req = 4'b1110;
    reset_pulse();
    @(negedge clk);
    frame = 1'b0; irdy = 1'b0;
    @(negedge clk);
    check("t5_busy", bus_busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_busy_gnt", gnt, 4'b1111);
    check("t5_rst_busy", bus_busy, 1'b0);
    check("t5_rst_busy_valid", gnt_valid, 1'b0);
    #1 reset = 1'b0;
    frame = 1'b1; irdy = 1'b1; req = 4'b0111;
    @(negedge clk);
    check("t5_gnt3", gnt, 4'b0111);
    check("t5_gnt3_id", gnt_id, 3);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_grant_gnt", gnt, 4'b1111);
    check("t5_rst_grant_valid", gnt_valid, 1'b0);
    #1 reset = 1'b0;
    req = 4'b1111;
    @(negedge clk);

`ifdef PCI_ARB_PARK_EN
    // T6: parking and hand-off to another master
    req = 4'b1111;
    reset_pulse();
    @(negedge clk);
    check("t6_parked", gnt, 4'b1110);
    req = 4'b1011;
    @(negedge clk);
    check("t6_dead_cycle", gnt, 4'b1111);
    @(negedge clk);
    check("t6_gnt2", gnt, 4'b1011);
    req = 4'b1111;
    @(negedge clk);
`endif

    // Randomized traffic with varying frame activity
    reset_pulse();
    for (int blk = 0; blk < 6; blk++) begin
      pf = (blk % 3 == 0) ? 40 : ((blk % 3 == 1) ? 8 : 3);
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 7) == 0) begin
          for (int b = 0; b < N; b++) req[b] = ($urandom_range(0, 2) != 0);
        end
        frame = ($urandom_range(0, pf - 1) != 0);
        irdy  = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 499) == 0) begin
          #2 reset = 1'b1;
          #2 reset = 1'b0;
        end
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
